inst_fetch_queue: RTL and testbench

Instruction fetch stage directly downstream of the PC register wrapper. Takes the current PC, issues single-cycle-latency reads to instruction memory, and buffers each returned instruction with its PC in a DEPTH-entry FIFO. Presents entries to decode over a valid/ready handshake. Also produces the enable that tells the PC register when to advance, and supports a redirect flush that discards all wrong-path work.

---
 rtl/inst_fetch_queue.sv | 117 +++++++++++
 tb/tb_inst_fetch_queue.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: issues single-cycle-latency instruction memory
// reads at the current PC and buffers {PC, instruction} pairs for decode.
// It also tells the PC register when to advance, and a redirect Flush drops
// all wrong-path work.
module inst_fetch_queue #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] PC,
   output logic                  FetchEn,
   output logic                  IMemReq,
   output logic [DATA_WIDTH-1:0] IMemAddr,
   input  logic [DATA_WIDTH-1:0] IMemRdata,
   input  logic                  Flush,
   output logic                  ValidD,
   input  logic                  ReadyD,
   output logic [DATA_WIDTH-1:0] InstrD,
   output logic [DATA_WIDTH-1:0] PCD,
   output logic [DATA_WIDTH-1:0] PCPlus4D
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [CW:0]           DepthLim = (CW+1)'(DEPTH);
   localparam logic [CW-1:0]         CntOne   = CW'(1);
   localparam logic [AW-1:0]         PtrOne   = AW'(1);
   localparam logic [DATA_WIDTH-1:0] Four     = DATA_WIDTH'(4);

   logic [CW-1:0]         count_q, count_d;
   logic [AW-1:0]         head_q, head_d;
   logic [AW-1:0]         tail_q, tail_d;
   logic                  inFlight_q, inFlight_d;
   logic [DATA_WIDTH-1:0] inFlightPC_q, inFlightPC_d;
   logic [DATA_WIDTH-1:0] pcMem_q    [DEPTH];
   logic [DATA_WIDTH-1:0] instrMem_q [DEPTH];

   logic [CW:0]           occupancy;
   logic                  issue;
   logic                  push;
   logic                  pop;
   logic                  headValid;
   logic [DATA_WIDTH-1:0] headPC;

   // Issue only when a slot is reserved for the reply; a pop this cycle does not count.
   always_comb begin
      occupancy = {1'b0, count_q} + {{CW{1'b0}}, inFlight_q};
      issue     = !rst && !Flush && (occupancy < DepthLim);
      push      = inFlight_q && !Flush;
      headValid = !rst && !Flush && (count_q != '0);
      pop       = headValid && ReadyD;
      headPC    = pcMem_q[head_q];
   end

   assign FetchEn  = issue;
   assign IMemReq  = issue;
   assign IMemAddr = PC;
   assign ValidD   = headValid;
   assign PCD      = headValid ? headPC : '0;
   assign InstrD   = headValid ? instrMem_q[head_q] : '0;
   assign PCPlus4D = headValid ? (headPC + Four) : '0;

   // Next-state for occupancy, pointers and the outstanding-read tracker.
   always_comb begin
      count_d      = count_q;
      head_d       = head_q;
      tail_d       = tail_q;
      inFlight_d   = issue;
      inFlightPC_d = issue ? PC : inFlightPC_q;
      if (Flush) begin
         count_d    = '0;
         head_d     = '0;
         tail_d     = '0;
         inFlight_d = 1'b0;
      end else begin
         if (push) begin
            tail_d = tail_q + PtrOne;
         end
         if (pop) begin
            head_d = head_q + PtrOne;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
         endcase
      end
   end

   // Control state registers; reset overrides flush and everything else.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q      <= '0;
         head_q       <= '0;
         tail_q       <= '0;
         inFlight_q   <= 1'b0;
         inFlightPC_q <= '0;
      end else begin
         count_q      <= count_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         inFlight_q   <= inFlight_d;
         inFlightPC_q <= inFlightPC_d;
      end
   end

   // Entry storage: the returning read data is captured with the PC it was fetched from.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         pcMem_q[tail_q]    <= inFlightPC_q;
         instrMem_q[tail_q] <= IMemRdata;
      end
   end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: a PC register model, a one-cycle
// instruction memory model, an occupancy model for handshake outputs, and a
// scoreboard queue of {PC, instr} checked when decode accepts an entry.
module tb_inst_fetch_queue;

   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] PC;
   logic          FetchEn;
   logic          IMemReq;
   logic [DW-1:0] IMemAddr;
   logic [DW-1:0] IMemRdata;
   logic          Flush;
   logic          ValidD;
   logic          ReadyD;
   logic [DW-1:0] InstrD;
   logic [DW-1:0] PCD;
   logic [DW-1:0] PCPlus4D;

   int            checks   = 0;
   int            failures = 0;

   logic [63:0]   expQ [$];
   int            mCount;
   bit            mInf;
   logic [31:0]   pcReg;

   logic          lastValid;
   logic          lastFetch;
   logic [31:0]   lastPCD;
   logic [31:0]   lastPlus4;
   logic [31:0]   lastAddr;

   inst_fetch_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .PC       (PC),
      .FetchEn  (FetchEn),
      .IMemReq  (IMemReq),
      .IMemAddr (IMemAddr),
      .IMemRdata(IMemRdata),
      .Flush    (Flush),
      .ValidD   (ValidD),
      .ReadyD   (ReadyD),
      .InstrD   (InstrD),
      .PCD      (PCD),
      .PCPlus4D (PCPlus4D)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Contents of instruction memory as a function of address.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, check settled outputs, then clock and update models.
   task automatic applyStimulus(input logic r, input logic f, input logic rdy);
      logic        expFetch;
      logic        expValid;
      logic        fe;
      logic [31:0] addr;
      logic [63:0] ent;
      rst    = r;
      Flush  = f;
      ReadyD = rdy;
      PC     = pcReg;
      #1;
      expFetch = !r && !f && ((mCount + int'(mInf)) < DEPTH);
      expValid = !r && !f && (mCount != 0);
      checkOutput("fetchEn", 32'(FetchEn), 32'(expFetch));
      checkOutput("imemReq", 32'(IMemReq), 32'(expFetch));
      checkOutput("validD", 32'(ValidD), 32'(expValid));
      checkOutput("imemAddr", IMemAddr, pcReg);
      if (!ValidD) begin
         checkOutput("idleData", InstrD | PCD | PCPlus4D, 32'h0);
      end
      if (ValidD && rdy) begin
         checkOutput("sbPending", 32'(expQ.size() != 0), 32'h1);
         if (expQ.size() != 0) begin
            ent = expQ.pop_front();
            checkOutput("PCD", PCD, ent[63:32]);
            checkOutput("InstrD", InstrD, ent[31:0]);
            checkOutput("PCPlus4D", PCPlus4D, ent[63:32] + 32'd4);
         end
      end
      lastValid = ValidD;
      lastFetch = FetchEn;
      lastPCD   = PCD;
      lastPlus4 = PCPlus4D;
      lastAddr  = IMemAddr;
      fe        = FetchEn;
      addr      = IMemAddr;
      if (fe) expQ.push_back({addr, memWord(addr)});
      if (r || f) expQ.delete();
      if (r || f) begin
         mCount = 0;
         mInf   = 1'b0;
      end else begin
         if (mInf) mCount++;
         if (expValid && rdy) mCount--;
         mInf = expFetch;
      end
      @(posedge clk);
      #1;
      IMemRdata = fe ? memWord(addr) : 32'hBAD0_BAD0;
      if (r) pcReg = 32'h0;
      else if (fe) pcReg = pcReg + 32'd4;
   endtask

   // Bound on total simulation time.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] watchdog");
   end

   // Directed scenarios; every cycle is also checked against the models above.
   initial begin
      int firstV;
      int fetches;
      pcReg     = 32'h0;
      IMemRdata = 32'h0;
      mCount    = 0;
      mInf      = 1'b0;

      // Startup: two reset cycles, then free-running fetch with decode ready.
      repeat (2) applyStimulus(1'b1, 1'b0, 1'b1);
      firstV = -1;
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1);
         if (lastValid && firstV < 0) begin
            firstV = i;
            checkOutput("firstPCD", lastPCD, 32'h0);
            checkOutput("firstPlus4", lastPlus4, 32'h4);
         end
         if (i >= 2) checkOutput("noBubble", 32'(lastValid), 32'h1);
      end
      checkOutput("startLatency", 32'(firstV), 32'd2);

      // Backpressure: decode stalled fills the queue with exactly DEPTH requests.
      applyStimulus(1'b1, 1'b0, 1'b1);
      fetches = 0;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         fetches += int'(lastFetch);
      end
      checkOutput("bpFetches", 32'(fetches), 32'd4);
      checkOutput("bpHeadValid", 32'(lastValid), 32'h1);
      checkOutput("bpHeadPCD", lastPCD, 32'h0);

      // Full queue: a single pop, then issue resumes on the following cycle.
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("fullPopNoIssue", 32'(lastFetch), 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("resumeFetch", 32'(lastFetch), 32'h1);
      checkOutput("resumeAddr", lastAddr, 32'h10);
      repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
      repeat (10) applyStimulus(1'b0, 1'b0, 1'b1);

      // Flush with three entries queued and one read outstanding.
      applyStimulus(1'b1, 1'b0, 1'b1);
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
      pcReg = 32'h100;
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("flushValid", 32'(lastValid), 32'h0);
      checkOutput("flushNoIssue", 32'(lastFetch), 32'h0);
      firstV = -1;
      for (int i = 1; i < 9; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1);
         if (lastValid && firstV < 0) begin
            firstV = i;
            checkOutput("flushFirstPCD", lastPCD, 32'h100);
         end
      end
      checkOutput("flushLatency", 32'(firstV), 32'd3);

      // PC wrap at the top of the address space.
      applyStimulus(1'b1, 1'b0, 1'b1);
      pcReg  = 32'hFFFF_FFFC;
      firstV = -1;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1);
         if (lastValid && firstV < 0) begin
            firstV = i;
            checkOutput("wrapPCD", lastPCD, 32'hFFFF_FFFC);
            checkOutput("wrapPlus4", lastPlus4, 32'h0);
         end
      end
      checkOutput("wrapSeen", 32'(firstV), 32'd2);

      // Reset in the middle of activity with a read outstanding.
      applyStimulus(1'b1, 1'b0, 1'b1);
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("rstValid", 32'(lastValid), 32'h0);
      checkOutput("rstReq", 32'(lastFetch), 32'h0);
      pcReg = 32'h200;
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("postRstValid", 32'(lastValid), 32'h0);
      firstV = -1;
      for (int i = 1; i < 8; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1);
         if (lastValid && firstV < 0) begin
            firstV = i;
            checkOutput("postRstPCD", lastPCD, 32'h200);
         end
      end
      checkOutput("postRstLatency", 32'(firstV), 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
